nios_practica_button_pio: RTL and testbench

NIOS_PRACTICA_BUTTON_PIO -- requirements
Module: nios_practica_button_pio

---
 rtl/nios_practica_button_pio_pkg.sv | 21 ++
 rtl/nios_practica_button_pio_if.sv | 23 ++
 rtl/nios_practica_sync_edge.sv | 42 ++++
 rtl/nios_practica_button_pio.sv | 89 ++++++++
 tb/tb_nios_practica_button_pio.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/nios_practica_button_pio_pkg.sv
// Shared definitions for the Nios practica PIO blocks.
// Provides the Avalon-MM register addresses and the edge-type selector
// used for per-bit capture.
package nios_practica_pio_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    // Register map addresses; address 1 is reserved and reads as zero.
    localparam logic [ADDR_W-1:0] DATA         = 2'd0;
    localparam logic [ADDR_W-1:0] IRQ_MASK     = 2'd2;
    localparam logic [ADDR_W-1:0] EDGE_CAPTURE = 2'd3;

    // Input transition that sets an edge_capture bit.
    typedef enum logic [1:0] {
        RISING,
        FALLING,
        ANY
    } edge_type_e;

endpackage

// File: rtl/nios_practica_button_pio_if.sv
// Avalon-MM slave bus bundle for the button PIO.
// Ports: address, chipselect, write_n, writedata (master -> slave),
//        readdata (slave -> master).
interface nios_practica_button_pio_if;
    import nios_practica_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios_practica_sync_edge.sv
// Per-bit 2-flop synchronizer followed by a history flop and edge detector.
// Ports: clk, reset (sync, active-high), d_in (async input),
//        sync_q (synchronized level), edge_c (combinational edge flag).
module nios_practica_sync_edge
    import nios_practica_pio_pkg::*;
#(
    parameter edge_type_e EDGE_TYPE = ANY
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic sync_q,
    output logic edge_c
);

    logic meta_q;
    logic prev_q;

    // Synchronizer chain plus previous-value flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Edge qualification against the selected transition type.
    always_comb begin
        edge_c = 1'b0;
        case (EDGE_TYPE)
            RISING:  edge_c = sync_q & ~prev_q;
            FALLING: edge_c = ~sync_q & prev_q;
            default: edge_c = sync_q ^ prev_q;
        endcase
    end

endmodule

// File: rtl/nios_practica_button_pio.sv
// Button PIO: synchronized inputs, edge capture, IRQ masking, Avalon-MM regs.
// Ports: clk, reset (sync, active-high), in_port[WIDTH] (async buttons),
//        bus (Avalon-MM slave: address/chipselect/write_n/writedata/readdata),
//        irq (level interrupt, OR of masked captures).
module nios_practica_button_pio
    import nios_practica_pio_pkg::*;
#(
    parameter int unsigned      WIDTH            = 8,
    parameter edge_type_e       EDGE_TYPE        = ANY,
    parameter logic [WIDTH-1:0] RESET_VALUE_MASK = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_port,
    nios_practica_button_pio_if.slave bus,
    output logic                      irq
);

    logic [WIDTH-1:0]  sync_q;
    logic [WIDTH-1:0]  edge_c;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  irq_mask_nxt;
    logic [WIDTH-1:0]  edge_capture;
    logic [WIDTH-1:0]  edge_capture_nxt;
    logic [DATA_W-1:0] readdata_q;
    logic [DATA_W-1:0] readdata_nxt;
    logic              wr_en;
    logic [WIDTH-1:0]  wdata;
    logic              unused_wdata;

    // One synchronizer/edge detector per input bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        nios_practica_sync_edge #(
            .EDGE_TYPE (EDGE_TYPE)
        ) u_sync_edge (
            .clk    (clk),
            .reset  (reset),
            .d_in   (in_port[gi]),
            .sync_q (sync_q[gi]),
            .edge_c (edge_c[gi])
        );
    end

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    // Upper write-data bits carry no meaning for this block.
    assign unused_wdata = ^(bus.writedata >> WIDTH);

    // Register next-state: mask write, write-1-to-clear, set has priority.
    always_comb begin
        irq_mask_nxt     = irq_mask;
        edge_capture_nxt = edge_capture;
        if (wr_en && (bus.address == IRQ_MASK)) begin
            irq_mask_nxt = wdata;
        end
        if (wr_en && (bus.address == EDGE_CAPTURE)) begin
            edge_capture_nxt = edge_capture & ~wdata;
        end
        edge_capture_nxt = edge_capture_nxt | edge_c;
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        readdata_nxt = '0;
        case (bus.address)
            DATA:         readdata_nxt = DATA_W'(sync_q);
            IRQ_MASK:     readdata_nxt = DATA_W'(irq_mask);
            EDGE_CAPTURE: readdata_nxt = DATA_W'(edge_capture);
            default:      readdata_nxt = '0;
        endcase
    end

    // Register file and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= RESET_VALUE_MASK;
            edge_capture <= '0;
            readdata_q   <= '0;
        end else begin
            irq_mask     <= irq_mask_nxt;
            edge_capture <= edge_capture_nxt;
            readdata_q   <= readdata_nxt;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_practica_button_pio.sv
// Directed bench for nios_practica_button_pio: one RISING instance (dut_r,
// reset mask 8'h01) and one ANY instance (dut_a, reset mask 0).
module tb_nios_practica_button_pio;
    import nios_practica_pio_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] in_r;
    logic [7:0] in_a;
    logic       irq_r;
    logic       irq_a;
    logic [31:0] rd_q;

    int n_checks;
    int n_errs;

    nios_practica_button_pio_if bus_r ();
    nios_practica_button_pio_if bus_a ();

    nios_practica_button_pio #(
        .WIDTH            (8),
        .EDGE_TYPE        (RISING),
        .RESET_VALUE_MASK (8'h01)
    ) dut_r (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_r),
        .bus     (bus_r),
        .irq     (irq_r)
    );

    nios_practica_button_pio #(
        .WIDTH            (8),
        .EDGE_TYPE        (ANY),
        .RESET_VALUE_MASK (8'h00)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_a),
        .bus     (bus_a),
        .irq     (irq_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, landing 1ns after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_set(input int sel, input logic cs, input logic wn,
                           input logic [1:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_r.chipselect = cs;
            bus_r.write_n    = wn;
            bus_r.address    = a;
            bus_r.writedata  = d;
        end else begin
            bus_a.chipselect = cs;
            bus_a.write_n    = wn;
            bus_a.address    = a;
            bus_a.writedata  = d;
        end
    endtask

    // Single-cycle write; address is left in place afterwards.
    task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
        bus_set(sel, 1'b1, 1'b0, a, d);
        tick(1);
        bus_set(sel, 1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic rd(input int sel, input logic [1:0] a, output logic [31:0] q);
        bus_set(sel, 1'b0, 1'b1, a, 32'h0);
        tick(1);
        q = (sel == 0) ? bus_r.readdata : bus_a.readdata;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        reset    = 1'b1;
        in_r     = 8'h00;
        in_a     = 8'hA5;
        bus_set(0, 1'b0, 1'b1, DATA, 32'h0);
        bus_set(1, 1'b0, 1'b1, DATA, 32'h0);

        // Reset values
        tick(3);
        check("rst_rdata_r", bus_r.readdata, 32'h0);
        check("rst_rdata_a", bus_a.readdata, 32'h0);
        check("rst_irq_r", 32'(irq_r), 32'h0);
        check("rst_irq_a", 32'(irq_a), 32'h0);

        // Data register after reset with inputs held
        reset = 1'b0;
        tick(4);
        check("data_a5", bus_a.readdata, 32'h0000_00A5);
        check("data_r0", bus_r.readdata, 32'h0);
        check("irq_a_masked", 32'(irq_a), 32'h0);
        rd(1, 2'd1, rd_q);
        check("addr1_zero", rd_q, 32'h0);
        rd(0, IRQ_MASK, rd_q);
        check("mask_rstval_r", rd_q, 32'h01);
        rd(1, EDGE_CAPTURE, rd_q);
        check("startup_rise_a", rd_q, 32'hA5);
        wr(1, EDGE_CAPTURE, 32'hFF);
        rd(1, EDGE_CAPTURE, rd_q);
        check("clear_all_a", rd_q, 32'h0);

        // Rising edge on bit0, then clear
        wr(0, IRQ_MASK, 32'h01);
        in_r[0] = 1'b1;
        tick(2);
        check("irq_r_before_cap", 32'(irq_r), 32'h0);
        tick(1);
        check("irq_r_rise0", 32'(irq_r), 32'h1);
        rd(0, EDGE_CAPTURE, rd_q);
        check("cap_r_bit0", rd_q, 32'h01);
        wr(0, EDGE_CAPTURE, 32'h01);
        check("irq_r_cleared", 32'(irq_r), 32'h0);

        // Falling edge ignored; clear and set in the same cycle
        in_r[0] = 1'b0;
        tick(4);
        check("irq_r_fall_ign", 32'(irq_r), 32'h0);
        in_r[0] = 1'b1;
        tick(2);
        wr(0, EDGE_CAPTURE, 32'h01);
        check("set_wins_irq", 32'(irq_r), 32'h1);
        rd(0, EDGE_CAPTURE, rd_q);
        check("set_wins_cap", rd_q, 32'h01);
        wr(0, EDGE_CAPTURE, 32'h01);
        check("irq_r_clr2", 32'(irq_r), 32'h0);

        // Masked capture, then unmask
        wr(0, IRQ_MASK, 32'h00);
        in_r[3] = 1'b1;
        tick(3);
        check("irq_r_masked", 32'(irq_r), 32'h0);
        rd(0, EDGE_CAPTURE, rd_q);
        check("cap_r_bit3", rd_q, 32'h08);
        wr(0, IRQ_MASK, 32'h08);
        check("irq_r_unmask", 32'(irq_r), 32'h1);
        rd(0, EDGE_CAPTURE, rd_q);
        check("cap_r_kept", rd_q, 32'h08);

        // ANY: pulse bit2, clear, falling edge recaptures
        in_a = 8'h00;
        tick(4);
        wr(1, EDGE_CAPTURE, 32'hFF);
        rd(1, EDGE_CAPTURE, rd_q);
        check("cap_a_clear", rd_q, 32'h0);
        in_a = 8'h04;
        tick(5);
        in_a = 8'h00;
        rd(1, EDGE_CAPTURE, rd_q);
        check("cap_a_rise2", rd_q, 32'h04);
        wr(1, EDGE_CAPTURE, 32'h04);
        tick(1);
        check("cap_a_cleared", bus_a.readdata, 32'h0);
        tick(1);
        check("cap_a_fall2", bus_a.readdata, 32'h04);
        wr(1, IRQ_MASK, 32'hFFFF_FF00);
        rd(1, IRQ_MASK, rd_q);
        check("mask_upper_ign", rd_q, 32'h0);
        check("irq_a_mask0", 32'(irq_a), 32'h0);

        // Full capture, then reset mid-operation with a concurrent write
        wr(1, IRQ_MASK, 32'hFF);
        in_a = 8'hFF;
        tick(3);
        check("irq_a_full", 32'(irq_a), 32'h1);
        rd(1, EDGE_CAPTURE, rd_q);
        check("cap_a_ff", rd_q, 32'hFF);
        reset = 1'b1;
        bus_set(0, 1'b1, 1'b0, IRQ_MASK, 32'hFF);
        tick(1);
        bus_set(0, 1'b0, 1'b1, IRQ_MASK, 32'h0);
        check("mid_rst_irq_a", 32'(irq_a), 32'h0);
        check("mid_rst_rdata_a", bus_a.readdata, 32'h0);
        check("mid_rst_irq_r", 32'(irq_r), 32'h0);
        check("mid_rst_rdata_r", bus_r.readdata, 32'h0);
        reset = 1'b0;
        rd(0, IRQ_MASK, rd_q);
        check("rst_wr_discard", rd_q, 32'h01);
        rd(1, IRQ_MASK, rd_q);
        check("rst_mask_a", rd_q, 32'h0);
        rd(0, EDGE_CAPTURE, rd_q);
        check("rst_cap_r", rd_q, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
